// File: rtl/datapath_gen2_pkg.sv
// Shared encodings for the gen2 accumulator datapath: bus source codes, ALU
// opcodes, bit positions inside the ld/inc/clr strobe vectors and the
// memory-port FSM state type.
package datapath_gen2_pkg;

  // Bus source select
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // ALU operation select
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_LDA = 3'd2;
  localparam logic [2:0] ALU_CMA = 3'd3;
  localparam logic [2:0] ALU_CIR = 3'd4;
  localparam logic [2:0] ALU_CIL = 3'd5;
  localparam logic [2:0] ALU_INP = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  // ld bit order {TR,IR,E,AC,DR,PC,AR}
  localparam int unsigned LD_AR = 0;
  localparam int unsigned LD_PC = 1;
  localparam int unsigned LD_DR = 2;
  localparam int unsigned LD_AC = 3;
  localparam int unsigned LD_E  = 4;
  localparam int unsigned LD_IR = 5;
  localparam int unsigned LD_TR = 6;

  // inc bit order {E,AC,DR,PC,AR}
  localparam int unsigned INC_AR = 0;
  localparam int unsigned INC_PC = 1;
  localparam int unsigned INC_DR = 2;
  localparam int unsigned INC_AC = 3;
  localparam int unsigned INC_E  = 4;

  // clr bit order {IEN,E,AC,DR,PC,AR}
  localparam int unsigned CLR_AR  = 0;
  localparam int unsigned CLR_PC  = 1;
  localparam int unsigned CLR_DR  = 2;
  localparam int unsigned CLR_AC  = 3;
  localparam int unsigned CLR_E   = 4;
  localparam int unsigned CLR_IEN = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrWait
  } state_e;

endpackage

// File: rtl/dp2_alu.sv
// Combinational 8-op ALU for the gen2 datapath.
// Ports: alu_sel_i opcode, ac_i/dr_i/e_i operands, bus_i (INP source),
//        res_o WORD_W-bit result, e_o next value for E (E unless op changes it).
module dp2_alu
  import datapath_gen2_pkg::*;
#(
  parameter int unsigned WORD_W = 16
) (
  input  logic [2:0]        alu_sel_i,
  input  logic [WORD_W-1:0] ac_i,
  input  logic [WORD_W-1:0] dr_i,
  input  logic              e_i,
  input  logic [WORD_W-1:0] bus_i,
  output logic [WORD_W-1:0] res_o,
  output logic              e_o
);

  logic [WORD_W:0] sum;
  assign sum = {1'b0, ac_i} + {1'b0, dr_i};

  always_comb begin
    res_o = '0;
    e_o   = e_i;
    unique case (alu_sel_i)
      ALU_AND: res_o = ac_i & dr_i;
      ALU_ADD: begin
        res_o = sum[WORD_W-1:0];
        e_o   = sum[WORD_W];
      end
      ALU_LDA: res_o = dr_i;
      ALU_CMA: res_o = ~ac_i;
      ALU_CIR: begin
        res_o = {e_i, ac_i[WORD_W-1:1]};
        e_o   = ac_i[0];
      end
      ALU_CIL: begin
        res_o = {ac_i[WORD_W-2:0], e_i};
        e_o   = ac_i[WORD_W-1];
      end
      ALU_INP: res_o = bus_i;
      ALU_XOR: res_o = ac_i ^ dr_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_gen2.sv
// Gen2 accumulator datapath: AR, PC, DR, AC, IR, TR, E, IEN around a common
// bus and ALU, with a ready/valid memory port, stall FSM and timeout flag.
// Ports: clk/reset_n (sync active-low); bus_sel, ld, inc, clr, ien_set,
//        alu_sel, mem_wr from the sequencer; mem_* memory port; busy stall
//        indication; register/flag observation outputs.
module datapath_gen2
  import datapath_gen2_pkg::*;
#(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        bus_sel,
  input  logic [6:0]        ld,
  input  logic [4:0]        inc,
  input  logic [5:0]        clr,
  input  logic              ien_set,
  input  logic [2:0]        alu_sel,
  input  logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              mem_err,
  output logic [WORD_W-1:0] ac_out,
  output logic [WORD_W-1:0] dr_out,
  output logic [WORD_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ar_out,
  output logic              e_out,
  output logic              ien_out,
  output logic              z_flag,
  output logic              n_flag
);

  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int unsigned PadW = WORD_W - ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ar_q, ar_d, pc_q, pc_d;
  logic [WORD_W-1:0]   dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
  logic                e_q, e_d, ien_q, ien_d;
  logic [6:0]          ld_mask_q, ld_mask_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_err_q, mem_err_d;
  logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;

  logic [WORD_W-1:0]   bus, alu_res;
  logic                alu_e;
  logic                rd_launch, wr_launch, rd_done;
  logic [6:0]          ld_eff;
  logic [4:0]          inc_eff;
  logic [5:0]          clr_eff;
  logic                ien_set_eff;

  // While a read is outstanding the bus carries the returning memory data so
  // the completion edge reuses the normal load paths (including the ALU).
  always_comb begin
    bus = '0;
    case (bus_sel)
      BUS_NONE: bus = '0;
      BUS_AR:   bus = {{PadW{1'b0}}, ar_q};
      BUS_PC:   bus = {{PadW{1'b0}}, pc_q};
      BUS_DR:   bus = dr_q;
      BUS_AC:   bus = ac_q;
      BUS_IR:   bus = ir_q;
      BUS_TR:   bus = tr_q;
      BUS_MEM:  bus = mem_rdata;
    endcase
    if (state_q == StRdWait) bus = mem_rdata;
  end

  dp2_alu #(
    .WORD_W(WORD_W)
  ) u_alu (
    .alu_sel_i(alu_sel),
    .ac_i     (ac_q),
    .dr_i     (dr_q),
    .e_i      (e_q),
    .bus_i    (bus),
    .res_o    (alu_res),
    .e_o      (alu_e)
  );

  assign rd_launch = (state_q == StIdle) && (bus_sel == BUS_MEM) && (|ld);
  // A write is never launched with bus_sel=MEM: a read takes precedence.
  assign wr_launch = (state_q == StIdle) && mem_wr && (bus_sel != BUS_MEM);
  assign rd_done   = (state_q == StRdWait) && mem_ready;
  assign busy      = (state_q != StIdle) || rd_launch;

  // Strobes reaching the registers: sequencer strobes when not stalled, the
  // latched read destinations on read completion, nothing otherwise.
  always_comb begin
    ld_eff      = '0;
    inc_eff     = '0;
    clr_eff     = '0;
    ien_set_eff = 1'b0;
    if (rd_done) begin
      ld_eff = ld_mask_q;
    end else if (!busy) begin
      ld_eff      = ld;
      inc_eff     = inc;
      clr_eff     = clr;
      ien_set_eff = ien_set;
    end
  end

  // Register next state, priority clr > ld > inc
  always_comb begin
    ar_d = ar_q;
    if (clr_eff[CLR_AR])      ar_d = '0;
    else if (ld_eff[LD_AR])   ar_d = bus[ADDR_W-1:0];
    else if (inc_eff[INC_AR]) ar_d = ar_q + ADDR_W'(1);

    pc_d = pc_q;
    if (clr_eff[CLR_PC])      pc_d = '0;
    else if (ld_eff[LD_PC])   pc_d = bus[ADDR_W-1:0];
    else if (inc_eff[INC_PC]) pc_d = pc_q + ADDR_W'(1);

    dr_d = dr_q;
    if (clr_eff[CLR_DR])      dr_d = '0;
    else if (ld_eff[LD_DR])   dr_d = bus;
    else if (inc_eff[INC_DR]) dr_d = dr_q + WORD_W'(1);

    ac_d = ac_q;
    if (clr_eff[CLR_AC])      ac_d = '0;
    else if (ld_eff[LD_AC])   ac_d = alu_res;
    else if (inc_eff[INC_AC]) ac_d = ac_q + WORD_W'(1);

    e_d = e_q;
    if (clr_eff[CLR_E])       e_d = 1'b0;
    else if (ld_eff[LD_E])    e_d = alu_e;
    else if (inc_eff[INC_E])  e_d = ~e_q;

    ir_d = ld_eff[LD_IR] ? bus : ir_q;
    tr_d = ld_eff[LD_TR] ? bus : tr_q;

    ien_d = ien_q;
    if (clr_eff[CLR_IEN])     ien_d = 1'b0;
    else if (ien_set_eff)     ien_d = 1'b1;
  end

  // Memory-port FSM
  always_comb begin
    state_d     = state_q;
    ld_mask_d   = ld_mask_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        wait_cnt_d = '0;
        if (rd_launch) begin
          ld_mask_d = ld;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          state_d   = StRdWait;
        end else if (wr_launch) begin
          mem_wdata_d = bus;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          state_d     = StWrWait;
        end
      end
      StRdWait, StWrWait: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          ld_mask_d  = '0;
          wait_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          // Saturating count; the error is sticky and the wait continues.
          if (wait_cnt_q < CntW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + CntW'(1);
          if (wait_cnt_d == CntW'(MAX_WAIT)) mem_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ar_q        <= '0;
      pc_q        <= '0;
      dr_q        <= '0;
      ac_q        <= '0;
      ir_q        <= '0;
      tr_q        <= '0;
      e_q         <= 1'b0;
      ien_q       <= 1'b0;
      ld_mask_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ar_q        <= ar_d;
      pc_q        <= pc_d;
      dr_q        <= dr_d;
      ac_q        <= ac_d;
      ir_q        <= ir_d;
      tr_q        <= tr_d;
      e_q         <= e_d;
      ien_q       <= ien_d;
      ld_mask_q   <= ld_mask_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign mem_addr  = ar_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_err   = mem_err_q;
  assign ac_out    = ac_q;
  assign dr_out    = dr_q;
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign ar_out    = ar_q;
  assign e_out     = e_q;
  assign ien_out   = ien_q;
  assign z_flag    = (ac_q == '0);
  assign n_flag    = ac_q[WORD_W-1];

  // TR has no observation port; keep it referenced through the bus only.

endmodule

// File: tb/tb_datapath_gen2.sv
// Scoreboard bench for datapath_gen2: stimulus queues expected values, two
// monitors (register/flag sampler and memory-request watcher) compare them.
module tb_datapath_gen2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  bus_sel, alu_sel;
  logic [6:0]  ld;
  logic [4:0]  inc;
  logic [5:0]  clr;
  logic        ien_set, mem_wr, mem_ready;
  logic [11:0] mem_addr, pc_out, ar_out;
  logic [15:0] mem_wdata, mem_rdata, ac_out, dr_out, ir_out;
  logic        mem_req, mem_we, busy, mem_err, e_out, ien_out, z_flag, n_flag;

  datapath_gen2 #(
    .WORD_W  (16),
    .ADDR_W  (12),
    .MAX_WAIT(15)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus_sel  (bus_sel),
    .ld       (ld),
    .inc      (inc),
    .clr      (clr),
    .ien_set  (ien_set),
    .alu_sel  (alu_sel),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy),
    .mem_err  (mem_err),
    .ac_out   (ac_out),
    .dr_out   (dr_out),
    .ir_out   (ir_out),
    .pc_out   (pc_out),
    .ar_out   (ar_out),
    .e_out    (e_out),
    .ien_out  (ien_out),
    .z_flag   (z_flag),
    .n_flag   (n_flag)
  );

  always #5 clk = ~clk;

  // Independent encodings
  localparam logic [6:0] L_AR = 7'b0000001, L_PC = 7'b0000010, L_DR = 7'b0000100;
  localparam logic [6:0] L_AC = 7'b0001000, L_E  = 7'b0010000;
  localparam logic [4:0] I_PC = 5'b00010, I_DR = 5'b00100;
  localparam logic [5:0] C_AR = 6'b000001, C_E = 6'b010000, C_IEN = 6'b100000;
  localparam logic [2:0] A_AND = 3'd0, A_ADD = 3'd1, A_CMA = 3'd3, A_CIR = 3'd4;
  localparam logic [2:0] A_CIL = 3'd5, A_INP = 3'd6;

  localparam int S_AC = 0, S_DR = 1, S_IR = 2, S_PC = 3, S_AR = 4, S_E = 5, S_IEN = 6;
  localparam int S_Z = 7, S_N = 8, S_BUSY = 9, S_REQ = 10, S_WE = 11, S_WD = 12;
  localparam int S_ERR = 13, S_ADDR = 14;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } txn_t;

  chk_t chk_q[$];
  txn_t txn_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  chk_t mon_c;
  txn_t mon_t;
  logic prev_req = 1'b0;
  logic [31:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sig_val(input int id);
    logic [31:0] r;
    r = '0;
    case (id)
      S_AC:   r = {16'h0, ac_out};
      S_DR:   r = {16'h0, dr_out};
      S_IR:   r = {16'h0, ir_out};
      S_PC:   r = {20'h0, pc_out};
      S_AR:   r = {20'h0, ar_out};
      S_E:    r = {31'h0, e_out};
      S_IEN:  r = {31'h0, ien_out};
      S_Z:    r = {31'h0, z_flag};
      S_N:    r = {31'h0, n_flag};
      S_BUSY: r = {31'h0, busy};
      S_REQ:  r = {31'h0, mem_req};
      S_WE:   r = {31'h0, mem_we};
      S_WD:   r = {16'h0, mem_wdata};
      S_ERR:  r = {31'h0, mem_err};
      S_ADDR: r = {20'h0, mem_addr};
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  // Register/flag monitor
  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      mon_c = chk_q.pop_front();
      act = sig_val(mon_c.id);
      checks++;
      if (act !== mon_c.exp) begin
        errors++;
        $display("FAIL %s: got %0h want %0h (cycle %0d)", mon_c.name, act, mon_c.exp, cyc);
      end
    end
  end

  // Memory-request monitor: each new request is compared to the next txn
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      checks++;
      if (txn_q.size() == 0) begin
        errors++;
        $display("FAIL mem_req: got unexpected request want none (cycle %0d)", cyc);
      end else begin
        mon_t = txn_q.pop_front();
        if (mem_we !== mon_t.we || mem_addr !== mon_t.addr ||
            (mon_t.we && mem_wdata !== mon_t.wdata)) begin
          errors++;
          $display("FAIL mem_txn: got we=%0b addr=%0h wd=%0h want we=%0b addr=%0h wd=%0h",
                   mem_we, mem_addr, mem_wdata, mon_t.we, mon_t.addr, mon_t.wdata);
        end
      end
    end
    prev_req = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int id, input string nm, input logic [31:0] v);
    chk_q.push_back('{cyc, id, v, nm});
  endtask

  task automatic idle_in();
    bus_sel = 3'd0; ld = '0; inc = '0; clr = '0; ien_set = 1'b0;
    alu_sel = 3'd0; mem_wr = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Read launch + lat wait cycles, mem_ready on the last one
  task automatic rd(input logic [6:0] mask, input logic [2:0] op, input logic [15:0] data,
                    input int lat, input logic [11:0] addr);
    step();
    bus_sel = 3'd7; ld = mask; alu_sel = op;
    txn_q.push_back('{1'b0, addr, 16'h0});
    for (int i = 1; i <= lat; i++) begin
      step();
      bus_sel = 3'd0; ld = '0;
      mem_ready = (i == lat);
      mem_rdata = data;
    end
    step();
    mem_ready = 1'b0; mem_rdata = '0; alu_sel = 3'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_in();
    step();
    step();
    reset_n = 1'b1;

    // Reset: load some state, then a 1-cycle reset
    rd(L_AC, A_INP, 16'h1111, 1, 12'h000);
    expect_now(S_AC, "pre_reset_ac", 32'h1111);
    rd(L_PC, A_AND, 16'h0ABC, 1, 12'h000);
    expect_now(S_PC, "pre_reset_pc", 32'h0ABC);
    ien_set = 1'b1;
    step();
    ien_set = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    expect_now(S_AC, "rst_ac", 0);
    expect_now(S_PC, "rst_pc", 0);
    expect_now(S_DR, "rst_dr", 0);
    expect_now(S_IR, "rst_ir", 0);
    expect_now(S_AR, "rst_ar", 0);
    expect_now(S_E, "rst_e", 0);
    expect_now(S_IEN, "rst_ien", 0);
    expect_now(S_REQ, "rst_req", 0);
    expect_now(S_BUSY, "rst_busy", 0);
    expect_now(S_ERR, "rst_err", 0);
    expect_now(S_Z, "rst_z", 1);

    // Read, 3-cycle memory, concurrent inc PC ignored
    rd(L_AR, A_AND, 16'h0005, 1, 12'h000);
    expect_now(S_AR, "ar_load", 32'h005);
    step();
    bus_sel = 3'd7; ld = L_DR; inc = I_PC;
    txn_q.push_back('{1'b0, 12'h005, 16'h0});
    expect_now(S_BUSY, "rd_busy_launch", 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      bus_sel = 3'd0; ld = '0;
      mem_ready = (i == 3);
      mem_rdata = (i == 3) ? 16'hBEEF : 16'h0;
      expect_now(S_BUSY, "rd_busy_wait", 1);
      expect_now(S_REQ, "rd_req", 1);
      expect_now(S_ADDR, "rd_addr", 32'h005);
      if (i == 3) expect_now(S_DR, "rd_dr_before", 0);
    end
    step();
    mem_ready = 1'b0; mem_rdata = '0; inc = '0;
    expect_now(S_DR, "rd_dr", 32'hBEEF);
    expect_now(S_BUSY, "rd_busy_after", 0);
    expect_now(S_REQ, "rd_req_after", 0);
    expect_now(S_PC, "rd_pc_no_inc", 0);

    // ADD with carry
    rd(L_AC, A_INP, 16'hFFFF, 1, 12'h005);
    expect_now(S_N, "n_ffff", 1);
    rd(L_DR, A_AND, 16'h0001, 1, 12'h005);
    step();
    alu_sel = A_ADD; ld = L_AC | L_E;
    step();
    ld = '0;
    expect_now(S_AC, "add_ac", 0);
    expect_now(S_E, "add_e", 1);
    expect_now(S_Z, "add_z", 1);
    expect_now(S_N, "add_n", 0);
    alu_sel = A_CMA; ld = L_AC;
    step();
    ld = '0;
    expect_now(S_AC, "cma_ac", 32'hFFFF);

    // CIL then CIR
    rd(L_AC, A_INP, 16'h8001, 1, 12'h005);
    clr = C_E;
    step();
    clr = '0;
    expect_now(S_E, "clr_e", 0);
    alu_sel = A_CIL; ld = L_AC | L_E;
    step();
    expect_now(S_AC, "cil_ac", 32'h0002);
    expect_now(S_E, "cil_e", 1);
    alu_sel = A_CIR; ld = L_AC | L_E;
    step();
    ld = '0;
    expect_now(S_AC, "cir_ac", 32'h8001);
    expect_now(S_E, "cir_e", 0);

    // Write with concurrent inc DR, then timeout
    rd(L_AC, A_INP, 16'h1234, 1, 12'h005);
    bus_sel = 3'd4; mem_wr = 1'b1; inc = I_DR;
    txn_q.push_back('{1'b1, 12'h005, 16'h1234});
    expect_now(S_BUSY, "wr_launch_busy", 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      bus_sel = 3'd0; mem_wr = 1'b0; inc = '0;
      if (i == 1) begin
        expect_now(S_REQ, "wr_req", 1);
        expect_now(S_WE, "wr_we", 1);
        expect_now(S_WD, "wr_wdata", 32'h1234);
        expect_now(S_BUSY, "wr_busy", 1);
        expect_now(S_DR, "wr_concurrent_inc", 32'h0002);
      end
      if (i == 15) expect_now(S_ERR, "err_before", 0);
      if (i == 16) begin
        expect_now(S_ERR, "err_set", 1);
        expect_now(S_REQ, "err_still_req", 1);
      end
      mem_ready = (i == 16);
    end
    step();
    mem_ready = 1'b0;
    expect_now(S_REQ, "wr_done_req", 0);
    expect_now(S_BUSY, "wr_done_busy", 0);
    expect_now(S_ERR, "err_sticky", 1);
    step();
    expect_now(S_ERR, "err_sticky2", 1);

    // Priority and wrap
    rd(L_PC, A_AND, 16'h0FFF, 1, 12'h005);
    expect_now(S_PC, "pc_fff", 32'hFFF);
    inc = I_PC;
    step();
    inc = '0;
    expect_now(S_PC, "pc_wrap", 0);
    bus_sel = 3'd3; ld = L_AR | L_PC; clr = C_AR; inc = I_PC;
    step();
    bus_sel = 3'd0; ld = '0; clr = '0; inc = '0;
    expect_now(S_AR, "ar_clr_beats_ld", 0);
    expect_now(S_PC, "pc_ld_beats_inc", 32'h002);
    ien_set = 1'b1;
    step();
    expect_now(S_IEN, "ien_set", 1);
    clr = C_IEN;
    step();
    ien_set = 1'b0; clr = '0;
    expect_now(S_IEN, "ien_clr_wins", 0);

    // Reset during RD_WAIT abandons the read
    bus_sel = 3'd7; ld = L_DR;
    txn_q.push_back('{1'b0, 12'h000, 16'h0});
    step();
    bus_sel = 3'd0; ld = '0; mem_rdata = 16'hDEAD;
    expect_now(S_REQ, "rw_req", 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mem_ready = 1'b1;
    expect_now(S_REQ, "rw_req_dropped", 0);
    expect_now(S_BUSY, "rw_busy", 0);
    expect_now(S_ERR, "rw_err_cleared", 0);
    step();
    mem_ready = 1'b0; mem_rdata = '0;
    expect_now(S_DR, "rw_dr_unchanged", 0);
    expect_now(S_REQ, "rw_idle_ready_ignored", 0);
    step();
    step();

    checks++;
    if (chk_q.size() != 0) begin
      errors++;
      $display("FAIL chk_queue: got %0d pending want 0", chk_q.size());
    end
    checks++;
    if (txn_q.size() != 0) begin
      errors++;
      $display("FAIL txn_queue: got %0d pending want 0", txn_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_gen2.md
Name: datapath_gen2

Overview:
- Parametrised second-generation accumulator datapath: AR, PC, DR, AC, IR, TR, E, IEN around a common bus and ALU.
- Adds a ready/valid external memory port with variable latency, a stall FSM, a wait-timeout error flag, and a full 8-op ALU.
- Sits between the control sequencer (drives select, load, incr and clear strobes, and honours `busy`) and the memory subsystem.

Parameters:
- WORD_W, 16, width of DR, AC, IR, TR, bus and memory data.
- ADDR_W, 12, width of AR, PC and memory address; must satisfy ADDR_W < WORD_W.
- MAX_WAIT, 15, cycles `mem_ready` may stay low after `mem_req` before `mem_err` is raised.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- bus_sel  in  3  bus source: 0 none (zero), 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- ld  in  7  load strobes, bit order {TR,IR,E,AC,DR,PC,AR}.
- inc  in  5  increment strobes, bit order {E,AC,DR,PC,AR}.
- clr  in  6  clear strobes, bit order {IEN,E,AC,DR,PC,AR}.
- ien_set  in  1  set IEN.
- alu_sel  in  3  ALU operation.
- mem_wr  in  1  write the bus value to M[AR].
- mem_addr  out  ADDR_W  equals AR.
- mem_wdata  out  WORD_W  registered write data.
- mem_req  out  1  request, held until `mem_ready`.
- mem_we  out  1  1 = write, valid while `mem_req` is high.
- mem_rdata  in  WORD_W  read data, valid when `mem_ready` is high.
- mem_ready  in  1  completes the current request.
- busy  out  1  datapath stalled; the sequencer must freeze its step counter.
- mem_err  out  1  sticky timeout flag.
- ac_out, dr_out, ir_out  out  WORD_W  register values.
- pc_out, ar_out  out  ADDR_W  register values.
- e_out, ien_out, z_flag, n_flag  out  1  E, IEN, AC==0, AC[WORD_W-1].

Behaviour:
- Reset (reset_n=0 at an edge):
  - All registers, FSM state, `mem_req`, `mem_we`, `mem_wdata` and `mem_err` go to 0.
  - Reset applies mid-transaction: the request is abandoned and latched strobes are discarded.
- Bus:
  - ADDR_W sources are zero-extended to WORD_W.
  - ADDR_W destinations take bus[ADDR_W-1:0].
  - AC and E load from the ALU, never directly from the bus.
- Per-register priority: clr > ld > inc.
  - Increments wrap modulo 2^width.
  - E increment toggles E.
  - IEN: clr beats ien_set.
- ALU, combinational on AC, DR, E. Result is WORD_W bits plus e_next; e_next = E unless stated.
  - 0 AND: AC & DR.
  - 1 ADD: AC + DR; e_next = carry out.
  - 2 LDA: DR.
  - 3 CMA: ~AC.
  - 4 CIR: {E, AC[W-1:1]}; e_next = AC[0].
  - 5 CIL: {AC[W-2:0], E}; e_next = AC[W-1].
  - 6 INP: bus[WORD_W-1:0].
  - 7 XOR: AC ^ DR.
- E load writes e_next.
- FSM states IDLE, RD_WAIT, WR_WAIT:
  - IDLE, bus_sel=7 with any ld bit set:
    - Latch the ld mask.
    - Assert mem_req=1, mem_we=0 next cycle; go to RD_WAIT.
    - No register loads this cycle.
  - IDLE, mem_wr=1:
    - Latch the bus into mem_wdata.
    - Assert mem_req=1, mem_we=1; go to WR_WAIT.
    - Other strobes in the same cycle act normally.
  - bus_sel=7 and mem_wr together: mem_wr is ignored; read wins.
  - RD_WAIT, mem_ready=1: latched destinations load mem_rdata. Within that edge, AC/E take the ALU result with mem_rdata as the bus; DR/IR/TR/AR/PC take mem_rdata. Drop mem_req; go to IDLE.
  - WR_WAIT, mem_ready=1: drop mem_req; go to IDLE.
- busy: high in RD_WAIT and WR_WAIT, and combinationally high in IDLE when a read is being launched.
  - While busy, all ld/inc/clr/ien_set/mem_wr inputs are ignored.
  - AR is frozen, so mem_addr is stable.
- Timeout: a wait counter counts cycles in a WAIT state.
  - When it reaches MAX_WAIT, mem_err is set; the FSM keeps waiting.
  - mem_err clears only on reset.
- mem_ready while in IDLE is ignored.
- Flags z_flag and n_flag are combinational from AC.

Decomposition:
- Package datapath_gen2_pkg holds:
  - bus_sel codes (BUS_NONE..BUS_MEM);
  - alu_sel codes (ALU_AND..ALU_XOR);
  - ld/inc/clr bit-index constants;
  - FSM state enum.
- One sub-module, dp2_alu: combinational, parametrised by WORD_W.
- Registers are inline always blocks.

Test Plan:
- Reset: drive values in, then reset_n=0 for 1 cycle → all outputs 0, mem_req=0, busy=0.
- Read with a 3-cycle memory: AR=0x005, bus_sel=7, ld DR, mem_rdata=0xBEEF with mem_ready on the 3rd wait cycle.
  - busy is high for 4 cycles; DR=0xBEEF on the next edge; concurrent inc PC strobes are ignored.
- ADD carry: AC=0xFFFF, DR=0x0001, alu_sel=1, ld AC and E → AC=0x0000, E=1, z_flag=1.
- CIL/CIR: AC=0x8001, E=0.
  - CIL → AC=0x0002, E=1.
  - Then CIR → AC=0x8001, E=0.
- Write then timeout: AC=0x1234, bus_sel=4, mem_wr → mem_wdata=0x1234, mem_we=1; hold mem_ready=0 for 15 cycles → mem_err=1, stays 1 after mem_ready until reset.
- Priority and wrap:
  - PC=0xFFF, inc PC → PC=0x000.
  - ld+clr AR in one cycle → AR=0.
  - ien_set+clr IEN → IEN=0.
  - Reset asserted in RD_WAIT → mem_req=0 next cycle, destination unchanged.
